// File: rtl/light_driver_pkg.sv
// Shared light codes, lamp colours and FSM encodings for the light driver.
package light_driver_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_GREEN  = 2'b01,
    LIGHT_YELLOW = 2'b10,
    LIGHT_WALK   = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    ST_TEST  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  // Colours are {R,G,B}.
  localparam logic [2:0] RGB_OFF    = 3'b000;
  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_GREEN  = 3'b010;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_WHITE  = 3'b111;

  function automatic logic [2:0] car_colour(input light_t light);
    logic [2:0] rgb;
    case (light)
      LIGHT_GREEN:  rgb = RGB_GREEN;
      LIGHT_YELLOW: rgb = RGB_YELLOW;
      default:      rgb = RGB_RED;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/light_driver_pwm_gate.sv
// Free-running PWM counter with duty compare; en is high for C_PWM_DUTY counts per period.
module pwm_gate #(
  parameter int C_PWM_BITS = 4,
  parameter int C_PWM_DUTY = 8
) (
  input  logic clk,
  input  logic rstb,
  output logic en
);

  // Duty is clipped to the period so it fits the one-bit-wider compare.
  localparam int PERIOD = 2 ** C_PWM_BITS;
  localparam logic [C_PWM_BITS:0] DUTY_SAT =
    (C_PWM_DUTY >= PERIOD) ? (C_PWM_BITS + 1)'(PERIOD) : (C_PWM_BITS + 1)'(C_PWM_DUTY);

  logic [C_PWM_BITS-1:0] cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign en = ({1'b0, cnt} < DUTY_SAT);

endmodule

// File: rtl/light_driver.sv
// Lamp driver: lamp test after reset, light-code to RGB mapping, flashing end of walk,
// frozen-code watchdog and PWM dimming of all lamp outputs.
module light_driver
  import light_driver_pkg::*;
#(
  parameter int C_PWM_BITS   = 4,
  parameter int C_PWM_DUTY   = 8,
  parameter int C_LAMP_TEST  = 4,
  parameter int C_WALK_LEN   = 100,
  parameter int C_WALK_FLASH = 20,
  parameter int C_WATCHDOG   = 250
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       blink,
  input  logic [1:0] inLight,
  input  logic       inPedRequest,
  output logic [2:0] outCarRgb,
  output logic [2:0] outWalkRgb,
  output logic       outWaitLed,
  output logic       outFault,
  output state_t     dbg_state
);

  localparam int TEST_W = $clog2(C_LAMP_TEST + 1);
  localparam int WD_W   = $clog2(C_WATCHDOG + 1);
  localparam int WALK_W = $clog2(C_WALK_LEN + 1);
  localparam logic [WALK_W-1:0] FLASH_START = WALK_W'(C_WALK_LEN - C_WALK_FLASH);

  state_t            state, state_nx;
  light_t            light, light_old;
  logic              blink_old;
  logic [TEST_W-1:0] test_cnt, test_nx;
  logic [WD_W-1:0]   wd_cnt, wd_nx;
  logic [WALK_W-1:0] walk_cnt, walk_nx;
  logic              flash, flash_nx;
  logic [2:0]        car_nx, walk_rgb_nx;
  logic              wait_nx, fault_nx;
  logic              tick, change, walk_entry, pwm_en;

  assign light      = light_t'(inLight);
  assign tick       = blink & ~blink_old;
  assign change     = (light != light_old);
  assign walk_entry = change & (light == LIGHT_WALK);
  assign dbg_state  = state;

  pwm_gate #(
    .C_PWM_BITS(C_PWM_BITS),
    .C_PWM_DUTY(C_PWM_DUTY)
  ) u_pwm_gate (
    .clk (clk),
    .rstb(rstb),
    .en  (pwm_en)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= ST_TEST;
      light_old <= LIGHT_RED;
      blink_old <= 1'b0;
      test_cnt  <= '0;
      wd_cnt    <= '0;
      walk_cnt  <= '0;
      flash     <= 1'b0;
    end else begin
      state     <= state_nx;
      light_old <= light;
      blink_old <= blink;
      test_cnt  <= test_nx;
      wd_cnt    <= wd_nx;
      walk_cnt  <= walk_nx;
      flash     <= flash_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    test_nx     = test_cnt;
    wd_nx       = wd_cnt;
    walk_nx     = walk_cnt;
    flash_nx    = flash;
    car_nx      = RGB_OFF;
    walk_rgb_nx = RGB_OFF;
    wait_nx     = 1'b0;
    fault_nx    = 1'b0;

    // Walk entry forces the flash phase on so the green starts lit.
    if (walk_entry) begin
      flash_nx = 1'b1;
    end else if (tick) begin
      flash_nx = ~flash;
    end

    if (walk_entry) begin
      walk_nx = '0;
    end else if (tick && (light == LIGHT_WALK) && (walk_cnt < WALK_W'(C_WALK_LEN))) begin
      walk_nx = walk_cnt + 1'b1;
    end

    case (state)
      ST_TEST: begin
        if (tick) begin
          if (test_cnt == TEST_W'(C_LAMP_TEST - 1)) begin
            state_nx = ST_RUN;
            test_nx  = '0;
            wd_nx    = '0;
            walk_nx  = '0;
          end else begin
            test_nx = test_cnt + 1'b1;
          end
        end
      end
      ST_RUN: begin
        // A code change outranks a coincident tick.
        if (change) begin
          wd_nx = '0;
        end else if (tick) begin
          if (wd_cnt == WD_W'(C_WATCHDOG - 1)) begin
            state_nx = ST_FAULT;
            wd_nx    = '0;
          end else begin
            wd_nx = wd_cnt + 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (change) begin
          state_nx = ST_RUN;
          wd_nx    = '0;
        end
      end
      default: state_nx = ST_TEST;
    endcase

    // Outputs are decoded from the next state so every input shows up one clk later.
    case (state_nx)
      ST_TEST: begin
        car_nx      = RGB_WHITE;
        walk_rgb_nx = RGB_WHITE;
        wait_nx     = 1'b1;
      end
      ST_RUN: begin
        car_nx  = car_colour(light);
        wait_nx = inPedRequest & (light != LIGHT_WALK);
        if (light == LIGHT_WALK) begin
          walk_rgb_nx = ((walk_nx >= FLASH_START) && !flash_nx) ? RGB_OFF : RGB_GREEN;
        end else begin
          walk_rgb_nx = RGB_RED;
        end
      end
      ST_FAULT: begin
        car_nx   = flash_nx ? RGB_YELLOW : RGB_OFF;
        fault_nx = 1'b1;
      end
      default: begin
        car_nx = RGB_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      outCarRgb  <= RGB_OFF;
      outWalkRgb <= RGB_OFF;
      outWaitLed <= 1'b0;
      outFault   <= 1'b0;
    end else begin
      outCarRgb  <= car_nx & {3{pwm_en}};
      outWalkRgb <= walk_rgb_nx & {3{pwm_en}};
      outWaitLed <= wait_nx & pwm_en;
      outFault   <= fault_nx;
    end
  end

endmodule

// File: tb/tb_light_driver.sv
// Bench for light_driver: a full-duty instance and a quarter-duty instance share stimulus
// and are compared every clock against a tick-level behavioural model.
module tb_light_driver;
  import light_driver_pkg::*;

  localparam int LAMP_TEST  = 4;
  localparam int WALK_LEN   = 100;
  localparam int WALK_FLASH = 20;
  localparam int WATCHDOG   = 250;
  localparam int PWM_PERIOD = 16;
  localparam int BLINK_CLKS = 10;

  localparam int M_TEST  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       blink = 1'b0;
  logic [1:0] in_light = 2'b00;
  logic       ped = 1'b0;

  logic [2:0] car, walk_rgb, car4, walk4;
  logic       wait_led, fault, wait4, fault4;
  state_t     dbg, dbg4;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  light_driver #(
    .C_PWM_BITS(4), .C_PWM_DUTY(16), .C_LAMP_TEST(LAMP_TEST),
    .C_WALK_LEN(WALK_LEN), .C_WALK_FLASH(WALK_FLASH), .C_WATCHDOG(WATCHDOG)
  ) dut (
    .clk(clk), .rstb(rstb), .blink(blink), .inLight(in_light), .inPedRequest(ped),
    .outCarRgb(car), .outWalkRgb(walk_rgb), .outWaitLed(wait_led), .outFault(fault),
    .dbg_state(dbg)
  );

  light_driver #(
    .C_PWM_BITS(4), .C_PWM_DUTY(4), .C_LAMP_TEST(LAMP_TEST),
    .C_WALK_LEN(WALK_LEN), .C_WALK_FLASH(WALK_FLASH), .C_WATCHDOG(WATCHDOG)
  ) dut_pwm4 (
    .clk(clk), .rstb(rstb), .blink(blink), .inLight(in_light), .inPedRequest(ped),
    .outCarRgb(car4), .outWalkRgb(walk4), .outWaitLed(wait4), .outFault(fault4),
    .dbg_state(dbg4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Blink: high for 2 clk out of every 10.
  int blink_phase = 0;
  always @(negedge clk) begin
    blink = (blink_phase < 2);
    blink_phase = (blink_phase + 1) % BLINK_CLKS;
  end

  // Reference model, stepped once per clock at the level of ticks and light codes.
  int   mode = M_TEST;
  int   lamp_ticks = 0;
  int   idle_ticks = 0;
  int   walk_ticks = 0;
  int   pwm_phase = 0;
  bit   flash = 1'b0;
  bit   prev_blink = 1'b0;
  logic [1:0] prev_light = 2'b00;

  function automatic logic [2:0] car_of(input logic [1:0] l);
    case (l)
      2'd1:    return 3'b010;
      2'd2:    return 3'b110;
      default: return 3'b100;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [10:0] e;
    logic [2:0]  c, w;
    bit          wt, ft, tick, change, entry, g16, g4;
    if (!rstb) begin
      mode = M_TEST; lamp_ticks = 0; idle_ticks = 0; walk_ticks = 0;
      pwm_phase = 0; flash = 1'b0; prev_blink = 1'b0; prev_light = 2'b00;
      e = '0;
    end else begin
      tick   = blink && !prev_blink;
      change = (in_light != prev_light);
      entry  = change && (in_light == 2'd3);
      if (entry) flash = 1'b1;
      else if (tick) flash = !flash;
      if (entry) walk_ticks = 0;
      else if (tick && in_light == 2'd3 && walk_ticks < WALK_LEN) walk_ticks++;
      if (mode == M_TEST) begin
        if (tick) begin
          lamp_ticks++;
          if (lamp_ticks == LAMP_TEST) begin
            mode = M_RUN; lamp_ticks = 0; idle_ticks = 0; walk_ticks = 0;
          end
        end
      end else if (mode == M_RUN) begin
        if (change) idle_ticks = 0;
        else if (tick) begin
          idle_ticks++;
          if (idle_ticks == WATCHDOG) begin
            mode = M_FAULT; idle_ticks = 0;
          end
        end
      end else begin
        if (change) begin
          mode = M_RUN; idle_ticks = 0;
        end
      end
      prev_blink = blink;
      prev_light = in_light;

      c = 3'b000; w = 3'b000; wt = 1'b0; ft = 1'b0;
      if (mode == M_TEST) begin
        c = 3'b111; w = 3'b111; wt = 1'b1;
      end else if (mode == M_RUN) begin
        c  = car_of(in_light);
        wt = ped && (in_light != 2'd3);
        if (in_light != 2'd3) w = 3'b100;
        else if (walk_ticks >= WALK_LEN - WALK_FLASH && !flash) w = 3'b000;
        else w = 3'b010;
      end else begin
        c  = flash ? 3'b110 : 3'b000;
        ft = 1'b1;
      end
      g16 = (pwm_phase < 16);
      g4  = (pwm_phase < 4);
      pwm_phase = (pwm_phase + 1) % PWM_PERIOD;
      e = {c & {3{g16}}, w & {3{g16}}, wt & g16, ft, c & {3{g4}}};
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("car", 32'(car), 32'(e[10:8]));
      check("walk", 32'(walk_rgb), 32'(e[7:5]));
      check("wait", 32'(wait_led), 32'(e[4]));
      check("fault", 32'(fault), 32'(e[3]));
      check("car_duty4", 32'(car4), 32'(e[2:0]));
    end
  end

  task automatic hold(input logic [1:0] l, input int ticks);
    @(negedge clk);
    in_light = l;
    repeat (ticks * BLINK_CLKS - 1) @(negedge clk);
  endtask

  initial begin
    int high_cnt;
    repeat (3) @(negedge clk);
    check("reset_car", 32'(car), 32'd0);
    check("reset_walk", 32'(walk_rgb), 32'd0);
    check("reset_wait_fault", 32'({wait_led, fault}), 32'd0);
    rstb = 1'b1;

    // Lamp test, then red; measure the quarter-duty car lamp over one PWM period.
    hold(2'b00, 8);
    high_cnt = 0;
    repeat (PWM_PERIOD) begin
      @(negedge clk);
      if (car4[2]) high_cnt++;
    end
    check("duty4_high_count", 32'(high_cnt), 32'd4);

    ped = 1'($urandom_range(0, 1));
    hold(2'b01, 3);
    hold(2'b10, 2);

    // Full walk including flash phase and saturation.
    ped = 1'b1;
    hold(2'b01, 3);
    hold(2'b11, WALK_LEN + 5);
    hold(2'b00, 3);

    // Frozen code trips the watchdog; a change recovers.
    hold(2'b01, WATCHDOG + 10);
    hold(2'b10, 3);

    // Random codes with unaligned hold times exercise change/tick coincidence.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_light = 2'($urandom_range(0, 3));
      ped = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a walk.
    hold(2'b11, 30);
    #3 rstb = 1'b0;
    #1;
    check("async_car", 32'(car), 32'd0);
    check("async_walk", 32'(walk_rgb), 32'd0);
    check("async_wait_fault", 32'({wait_led, fault}), 32'd0);
    check("async_car_duty4", 32'(car4), 32'd0);
    repeat (3) @(negedge clk);
    in_light = 2'b00;
    rstb = 1'b1;
    hold(2'b00, 8);
    hold(2'b01, 2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
